// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 encodings of the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // funct3[2] separates the divide class from the multiply class
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder, subtract if it fits.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: rem/quot/divisor in -> rem_nxt/quot_nxt out (quot doubles as the dividend shift register).
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quot_nxt
);

    logic [XLEN:0] cand;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        cand     = {rem, quot[XLEN-1]};
        diff     = cand - {1'b0, divisor};
        // rem < divisor on entry, so a non-negative difference always fits in XLEN bits;
        // bit XLEN set therefore means the subtraction borrowed.
        fits     = ~diff[XLEN];
        rem_nxt  = fits ? diff[XLEN-1:0] : cand[XLEN-1:0];
        quot_nxt = {quot[XLEN-2:0], fits};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle MUL/DIV controller for EX: shift-add multiply, restoring divide, sign fix-up.
// Latency: done_o in cycle XLEN+2 counting the accept cycle as 0; divide special cases (and
//   multiplies when MULDIV_FAST_MUL_EN is defined) finish in cycle 2.
// Backpressure: stall_o freezes IF/ID/EX until the DONE cycle; flush_i aborts with no done_o.
// Ports: clk, rst_n (sync, active-low); start_i/funct3_i/op_a_i/op_b_i/rd_i/flush_i in;
//   stall_o, busy_o, done_o, result_o, rd_o out.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle (XLEN+1)x(XLEN+1) signed multiply.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc_q;     // MUL: {hi, lo} product; DIV: {rem, quot}; special: lo = result
    logic [XLEN-1:0]   b_q;       // multiplicand / divisor magnitude
    logic              neg_q;     // negate product or quotient in FIX
    logic              rneg_q;    // negate remainder in FIX
    logic              special_q; // result already sitting in acc_q low half
    logic [CNT_W-1:0]  cnt_q;

    // accept-time decode
    logic            acc_go;
    logic            op_is_div;
    logic            a_signed, b_signed;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        acc_go    = (state == ST_IDLE) && start_i && !flush_i;
        op_is_div = is_div_op(funct3_i);
        if (op_is_div) begin
            a_signed = ~funct3_i[0];
            b_signed = ~funct3_i[0];
        end else begin
            a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
            b_signed = (funct3_i == F3_MULH);
        end
        sa          = a_signed & op_a_i[XLEN-1];
        sb          = b_signed & op_b_i[XLEN-1];
        a_mag       = sa ? -op_a_i : op_a_i;
        b_mag       = sb ? -op_b_i : op_b_i;
        div_zero    = (op_b_i == '0);
        div_ovf     = ~funct3_i[0] && (op_a_i == MIN_NEG) && (op_b_i == '1);
        div_special = op_is_div && (div_zero || div_ovf);
        // funct3[1] marks REM/REMU
        if (div_zero) special_res = funct3_i[1] ? op_a_i : '1;
        else          special_res = funct3_i[1] ? '0 : MIN_NEG;
    end

    // multiply step: conditionally add the multiplicand into the high half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end

    logic [XLEN-1:0] rem_nxt, quot_nxt;

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc_q[2*XLEN-1:XLEN]),
        .quot     (acc_q[XLEN-1:0]),
        .divisor  (b_q),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fprod;

    always_comb begin
        fa    = {a_signed & op_a_i[XLEN-1], op_a_i};
        fb    = {b_signed & op_b_i[XLEN-1], op_b_i};
        fprod = fa * fb;
    end
`endif

    // fix-up: restore signs and pick the requested half / quotient / remainder
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        fix_res  = '0;
        if (special_q) begin
            fix_res = acc_q[XLEN-1:0];
        end else if (!is_div_op(f3_q)) begin
            fix_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (f3_q[1]) begin
            fix_res = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
            fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (acc_go) begin
                    if (op_is_div)        state_nxt = div_special ? ST_FIX : ST_DIV;
                    else begin
`ifdef MULDIV_FAST_MUL_EN
                                          state_nxt = ST_FIX;
`else
                                          state_nxt = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush_i)              state_nxt = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_nxt = ST_FIX;
            end
            ST_FIX:                       state_nxt = flush_i ? ST_IDLE : ST_DONE;
            ST_DONE:                      state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q      <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
            result_o  <= '0;
            rd_o      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acc_go) begin
                        f3_q      <= funct3_i;
                        rd_q      <= rd_i;
                        b_q       <= b_mag;
                        cnt_q     <= '0;
                        neg_q     <= sa ^ sb;
                        rneg_q    <= sa;
                        special_q <= div_special;
                        if (div_special) begin
                            acc_q <= {{XLEN{1'b0}}, special_res};
                        end else if (op_is_div) begin
                            acc_q <= {{XLEN{1'b0}}, a_mag};
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc_q <= fprod[2*XLEN-1:0];
                            neg_q <= 1'b0;
`else
                            acc_q <= {{XLEN{1'b0}}, a_mag};
`endif
                        end
                    end
                end
                ST_MUL: begin
                    acc_q <= mul_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_DIV: begin
                    acc_q <= {rem_nxt, quot_nxt};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_FIX: begin
                    if (!flush_i) begin
                        result_o <= fix_res;
                        rd_o     <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state != ST_IDLE);
    assign done_o  = (state == ST_DONE);
    assign stall_o = ((state == ST_IDLE) && start_i) || (state == ST_MUL) ||
                     (state == ST_DIV) || (state == ST_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 2;
`else
    localparam int MLAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .funct3_i (funct3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .rd_i     (rd_in),
        .flush_i  (flush),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    // Launch one op once the unit is idle; lat counts clock edges from the accept edge
    // (inclusive) to the cycle where done_o is seen, stalls counts stall_o cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rdv, input bit keep,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int stalls);
        int guard = 0;
        @(negedge clk);
        while (busy_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        rd_in  = rdv;
        #1;
        stalls = stall_o ? 1 : 0;
        lat    = 0;
        res    = 'x;
        rdo    = 'x;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_o) begin
                res = result_o;
                rdo = rd_o;
                check("stall_in_done", {31'b0, stall_o}, 32'd0);
                break;
            end
            if (stall_o) stalls++;
        end
        if (!keep) start = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, stalls, n;
        logic        done_seen;

        vecs[0]  = '{F3_MUL,    32'd6,        32'd7,        5'd1,  32'd42,       MLAT};
        vecs[1]  = '{F3_MUL,    32'hFFFFFFFA, 32'd7,        5'd2,  32'hFFFFFFD6, MLAT};
        vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MLAT};
        vecs[3]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, MLAT};
        vecs[4]  = '{F3_DIV,    32'd7,        32'd0,        5'd7,  32'hFFFFFFFF, 2};
        vecs[5]  = '{F3_REMU,   32'd7,        32'd0,        5'd8,  32'd7,        2};
        vecs[6]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 2};
        vecs[7]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 2};
        vecs[8]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 34};
        vecs[9]  = '{F3_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       34};
        vecs[10] = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd13, 32'hFFFFFFFF, MLAT};
        vecs[11] = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFD, 34};
        vecs[12] = '{F3_MULH,   32'h80000000, 32'h80000000, 5'd15, 32'h40000000, MLAT};

        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall",  {31'b0, stall_o}, 32'd0);
        check("rst_busy",   {31'b0, busy_o},  32'd0);
        check("rst_done",   {31'b0, done_o},  32'd0);
        check("rst_result", result_o,         32'd0);
        check("rst_rd",     {27'b0, rd_o},    32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0, res, rdo, lat, stalls);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_rd", i), {27'b0, rdo}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].lat);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_one_cycle", i), {31'b0, done_o}, 32'd0);
        end

        // flush in the tenth cycle of a divide: no done, idle right after
        @(negedge clk);
        start  = 1'b1;
        funct3 = F3_DIV;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd20;
        @(posedge clk);
        done_seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            done_seen |= done_o;
        end
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("flush_busy",  {31'b0, busy_o},  32'd0);
        check("flush_done",  {31'b0, done_o},  32'd0);
        check("flush_stall", {31'b0, stall_o}, 32'd0);
        check("flush_no_done_during_op", {31'b0, done_seen}, 32'd0);
        check("flush_result_held", result_o, vecs[12].res);
        flush = 1'b0;
        run_op(F3_DIVU, 32'd100, 32'd7, 5'd21, 1'b0, res, rdo, lat, stalls);
        check("post_flush_divu", res, 32'd14);
        check("post_flush_lat", lat, 34);

        // back-to-back: MUL rd5 then DIVU rd6 with start held through DONE
        run_op(F3_MUL, 32'd3, 32'd5, 5'd5, 1'b1, res, rdo, lat, stalls);
        check("b2b_first_result", res, 32'd15);
        check("b2b_first_rd", {27'b0, rdo}, 32'd5);
        funct3 = F3_DIVU;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd6;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("b2b_idle_busy",  {31'b0, busy_o},  32'd0);
                check("b2b_idle_stall", {31'b0, stall_o}, 32'd1);
            end
            if (done_o) break;
        end
        start = 1'b0;
        check("b2b_second_gap", n, 35);
        check("b2b_second_result", result_o, 32'd14);
        check("b2b_second_rd", {27'b0, rd_o}, 32'd6);

        // reset in the middle of an op discards it
        @(negedge clk);
        start  = 1'b1;
        funct3 = F3_DIVU;
        op_a   = 32'd50;
        op_b   = 32'd3;
        rd_in  = 5'd25;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy",   {31'b0, busy_o}, 32'd0);
        check("midrst_done",   {31'b0, done_o}, 32'd0);
        check("midrst_result", result_o,        32'd0);
        check("midrst_rd",     {27'b0, rd_o},   32'd0);
        rst_n = 1'b1;
        run_op(F3_MUL, 32'd6, 32'd7, 5'd1, 1'b0, res, rdo, lat, stalls);
        check("after_rst_mul", res, 32'd42);
        check("after_rst_lat", lat, MLAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
